alu_seq_unit: RTL and testbench
===============================

// Module: alu_seq_unit
// PURPOSE
//   Datapath ALU stage that consumes operand A from the ALU A-mux and operand B from the B-mux.
//   It computes the result under the control unit's start/done handshake and drives alu_out
//   toward the register file / MDR write-back path.
//   Add, subtract, increment, decrement, pass and clear complete in 1 cycle.
//   Multiply is an iterative shift-add (one multiplier bit per cycle), used for the matrix-index
//   and address arithmetic.
// PARAMETERS
//   WIDTH  18  datapath width of operands and result
//   CNT_W   5  width of multiply iteration counter (must hold WIDTH-1)
// PORTS
//   clk      in   1      single clock; all state updates on rising edge
//   rstn     in   1      synchronous active-low reset, sampled on rising edge of clk
//   alu_a    in   WIDTH  operand A (from ALU A-mux)
//   alu_b    in   WIDTH  operand B (from ALU B-mux)
//   alu_op   in   3      operation code, sampled only on accept
//   start    in   1      request; accepted only when busy==0
//   alu_out  out  WIDTH  registered result; holds until next completion
//   z_flag   out  1      registered; 1 when alu_out==0, updated with alu_out
//   busy     out  1      1 while a multiply is iterating
//   done     out  1      one-cycle pulse: alu_out/z_flag valid and new
// BEHAVIOUR
// - Reset (rstn==0 at edge): state=IDLE, alu_out=0, z_flag=1, busy=0, done=0, counter=0.
//   Applies mid-multiply too: the operation is aborted and no done pulse occurs.
// - Opcodes: 000 PASS_A, 001 ADD a+b, 010 SUB a-b, 011 MUL a*b, 100 INC a+1, 101 DEC a-1,
//   110 PASS_B, 111 CLR (0).
// - All arithmetic is unsigned modulo 2^WIDTH; carries and borrows are discarded. MUL keeps the
//   low WIDTH bits of the product.
// - FSM states: IDLE, MUL.
//   - Accept = start && state==IDLE.
//   - start while busy is ignored (no queuing).
// - Single-cycle ops: on the accept edge, alu_out and z_flag are loaded and done is set to 1.
//   The state stays IDLE. Latency: done=1 in the cycle after the accept edge.
//   Back-to-back accepts every cycle are legal; done then stays high continuously.
// - MUL:
//   - Accept edge: latch a_sh=alu_a, b_sh=alu_b, acc=0, cnt=0; state->MUL; busy=1; done=0.
//   - Each MUL edge: if b_sh[0], acc+=a_sh; a_sh<<=1; b_sh>>=1; cnt++.
//   - On the edge where cnt==WIDTH-1 (WIDTH-th iteration): alu_out=acc_next, z_flag updated,
//     done=1, busy=0, state->IDLE.
//   - Fixed latency: done high exactly WIDTH cycles after the accept edge; busy high for WIDTH
//     cycles. There is no early termination on a zero multiplier.
// - A start in the cycle where done is high (state IDLE) is accepted normally.
// - alu_a, alu_b and alu_op changes during MUL have no effect; operands are latched on accept.
// - done is 0 in every cycle not immediately following a completion edge.
// TESTING
// 1. Reset, then ADD a=5, b=7, start 1 cycle -> next cycle done=1, alu_out=12, z_flag=0, busy=0.
// 2. SUB a=3, b=5 -> alu_out=262142 (wrap), done after 1 cycle.
//    DEC a=0 -> alu_out=262143.
// 3. MUL a=300, b=400 -> busy=1 for 18 cycles; done exactly 18 cycles after accept;
//    alu_out=120000.
// 4. MUL a=1000, b=1000 -> alu_out=213568 (mod 2^18).
//    MUL a=0, b=77 -> alu_out=0, z_flag=1, still 18-cycle latency.
// 5. During a MUL, pulse start with ADD 1+1 and change alu_a -> ignored; MUL result unchanged;
//    a single done pulse.
// 6. Reset asserted at MUL iteration 9 -> next cycle busy=0, done=0, alu_out=0;
//    no done afterwards. CLR after a nonzero result -> alu_out=0, z_flag=1.

Source files
------------

// File: rtl/alu_seq_unit_if.sv
// ---------------------------------------------------------------------------
// alu_seq_unit_if
//   Bundle between the control unit (master) and the ALU stage (slave).
//
//   Handshake: the master raises start with alu_a/alu_b/alu_op valid. The
//   request is taken on a rising clk edge where start==1 and busy==0.
//   While busy==1 start is ignored, not queued. done is a one-cycle pulse
//   marking alu_out/z_flag as new. The master must re-check busy before
//   each new request.
//
//   Signals
//     alu_a, alu_b  operand A / operand B              (master -> slave)
//     alu_op        3-bit operation code               (master -> slave)
//     start         request strobe                     (master -> slave)
//     alu_out       registered result                  (slave -> master)
//     z_flag        alu_out == 0                       (slave -> master)
//     busy          multiply in progress               (slave -> master)
//     done          result-valid pulse                 (slave -> master)
// ---------------------------------------------------------------------------
interface alu_seq_unit_if #(
   parameter int WIDTH = 18
);
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_op;
   logic             start;
   logic [WIDTH-1:0] alu_out;
   logic             z_flag;
   logic             busy;
   logic             done;

   modport master (
      output alu_a, alu_b, alu_op, start,
      input  alu_out, z_flag, busy, done
   );

   modport slave (
      input  alu_a, alu_b, alu_op, start,
      output alu_out, z_flag, busy, done
   );
endinterface

// File: rtl/alu_seq_unit.sv
// ---------------------------------------------------------------------------
// alu_seq_unit
//   Datapath ALU stage. Single-cycle ops (pass, add, sub, inc, dec, clear)
//   finish on the accept edge. MUL is a shift-add multiply that processes
//   one multiplier bit per cycle. It has a fixed latency of WIDTH cycles and
//   does not terminate early.
//
//   Ports
//     clk        rising-edge clock
//     rstn       synchronous active-low reset
//     bus        alu_seq_unit_if.slave (operands, opcode, start, results)
//     state_dbg  current FSM state (0 = IDLE, 1 = MUL)
// ---------------------------------------------------------------------------
module alu_seq_unit #(
   parameter int WIDTH = 18,
   parameter int CNT_W = 5
) (
   input  logic               clk,
   input  logic               rstn,
   alu_seq_unit_if.slave      bus,
   output logic [0:0]         state_dbg
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_MUL  = 1'b1;

   localparam logic [2:0] OP_PASS_A = 3'b000;
   localparam logic [2:0] OP_ADD    = 3'b001;
   localparam logic [2:0] OP_SUB    = 3'b010;
   localparam logic [2:0] OP_MUL    = 3'b011;
   localparam logic [2:0] OP_INC    = 3'b100;
   localparam logic [2:0] OP_DEC    = 3'b101;
   localparam logic [2:0] OP_PASS_B = 3'b110;
   localparam logic [2:0] OP_CLR    = 3'b111;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   logic [0:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] out_q;
   logic             z_q;
   logic             busy_q;
   logic             done_q;

   logic [WIDTH-1:0] acc_next;
   logic [WIDTH-1:0] single_res;

   // One shift-add step. The sum wraps at WIDTH bits, so only the low half
   // of the product is kept.
   always_comb begin
      acc_next = acc;
      if (b_sh[0]) acc_next = acc + a_sh;
   end

   always_comb begin
      single_res = '0;
      case (bus.alu_op)
         OP_PASS_A: single_res = bus.alu_a;
         OP_ADD:    single_res = bus.alu_a + bus.alu_b;
         OP_SUB:    single_res = bus.alu_a - bus.alu_b;
         OP_INC:    single_res = bus.alu_a + WIDTH'(1);
         OP_DEC:    single_res = bus.alu_a - WIDTH'(1);
         OP_PASS_B: single_res = bus.alu_b;
         OP_CLR:    single_res = '0;
         default:   single_res = '0;   // OP_MUL does not use this path
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state  <= ST_IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         acc    <= '0;
         cnt    <= '0;
         out_q  <= '0;
         z_q    <= 1'b1;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  if (bus.alu_op == OP_MUL) begin
                     a_sh   <= bus.alu_a;
                     b_sh   <= bus.alu_b;
                     acc    <= '0;
                     cnt    <= '0;
                     busy_q <= 1'b1;
                     state  <= ST_MUL;
                  end else begin
                     out_q  <= single_res;
                     z_q    <= (single_res == '0);
                     done_q <= 1'b1;
                  end
               end
            end
            ST_MUL: begin
               acc  <= acc_next;
               a_sh <= a_sh << 1;
               b_sh <= b_sh >> 1;
               cnt  <= cnt + CNT_W'(1);
               // The WIDTH-th step publishes the accumulator including
               // this step's addend.
               if (cnt == LAST_ITER) begin
                  out_q  <= acc_next;
                  z_q    <= (acc_next == '0);
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.alu_out = out_q;
   assign bus.z_flag  = z_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign state_dbg   = state;

endmodule

// File: tb/tb_alu_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_unit
//   Directed-vector bench for alu_seq_unit. Inputs change 1 ns after a
//   rising edge, and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_alu_seq_unit;

   localparam int W = 18;

   localparam logic [2:0] OP_PASS_A = 3'b000;
   localparam logic [2:0] OP_ADD    = 3'b001;
   localparam logic [2:0] OP_SUB    = 3'b010;
   localparam logic [2:0] OP_MUL    = 3'b011;
   localparam logic [2:0] OP_INC    = 3'b100;
   localparam logic [2:0] OP_DEC    = 3'b101;
   localparam logic [2:0] OP_PASS_B = 3'b110;
   localparam logic [2:0] OP_CLR    = 3'b111;

   logic       clk;
   logic       rstn;
   logic [0:0] state_dbg;
   int         checks;
   int         errors;
   logic [W-1:0] exp_q[$];

   alu_seq_unit_if #(.WIDTH(W)) bus ();

   alu_seq_unit #(.WIDTH(W), .CNT_W(5)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .bus       (bus.slave),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.alu_op = op;
      bus.alu_a  = a;
      bus.alu_b  = b;
      bus.start  = 1'b1;
   endtask

   task automatic single_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      drive(op, a, b);
      tick();
      bus.start = 1'b0;
   endtask

   // Runs a multiply from the accept edge through the done sample. It can
   // also inject an ignored ADD request and an operand change mid-run.
   task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit inject,
                          output int lat, output int busy_cycles);
      drive(OP_MUL, a, b);
      tick();
      bus.start   = 1'b0;
      lat         = 0;
      busy_cycles = 0;
      while (bus.done !== 1'b1 && lat < 40) begin
         if (bus.busy === 1'b1) busy_cycles++;
         if (inject && lat == 5) drive(OP_ADD, 18'd1, 18'd1);
         if (inject && lat == 6) begin
            bus.start = 1'b0;
            bus.alu_a = 18'd999;
         end
         tick();
         lat++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rstn = 1'b0;
      tick();
      tick();
      checks++;
      if (bus.alu_out !== 18'd0 || bus.z_flag !== 1'b1 || bus.busy !== 1'b0 ||
          bus.done !== 1'b0 || state_dbg !== 1'b0) begin
         errors++;
         $display("FAIL reset: out=%0d z=%b busy=%b done=%b st=%b, exp 0/1/0/0/0",
                  bus.alu_out, bus.z_flag, bus.busy, bus.done, state_dbg);
      end
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_add();
      single_op(OP_ADD, 18'd5, 18'd7);
      checks++;
      if (bus.done !== 1'b1 || bus.alu_out !== 18'd12 || bus.z_flag !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL add: done=%b out=%0d z=%b busy=%b, exp 1/12/0/0",
                  bus.done, bus.alu_out, bus.z_flag, bus.busy);
      end
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.alu_out !== 18'd12) begin
         errors++;
         $display("FAIL add_hold: done=%b out=%0d, exp 0/12", bus.done, bus.alu_out);
      end
   endtask

   task automatic test_wrap();
      single_op(OP_SUB, 18'd3, 18'd5);
      checks++;
      if (bus.done !== 1'b1 || bus.alu_out !== 18'd262142) begin
         errors++;
         $display("FAIL sub_wrap: done=%b out=%0d, exp 1/262142", bus.done, bus.alu_out);
      end
      single_op(OP_DEC, 18'd0, 18'd9);
      checks++;
      if (bus.alu_out !== 18'd262143 || bus.z_flag !== 1'b0) begin
         errors++;
         $display("FAIL dec_wrap: out=%0d z=%b, exp 262143/0", bus.alu_out, bus.z_flag);
      end
      single_op(OP_INC, 18'd262143, 18'd0);
      checks++;
      if (bus.alu_out !== 18'd0 || bus.z_flag !== 1'b1) begin
         errors++;
         $display("FAIL inc_wrap: out=%0d z=%b, exp 0/1", bus.alu_out, bus.z_flag);
      end
      single_op(OP_PASS_A, 18'd1234, 18'd77);
      checks++;
      if (bus.alu_out !== 18'd1234) begin
         errors++;
         $display("FAIL pass_a: out=%0d, exp 1234", bus.alu_out);
      end
      single_op(OP_PASS_B, 18'd1234, 18'd77);
      checks++;
      if (bus.alu_out !== 18'd77) begin
         errors++;
         $display("FAIL pass_b: out=%0d, exp 77", bus.alu_out);
      end
   endtask

   task automatic test_mul();
      int lat;
      int bc;
      run_mul(18'd300, 18'd400, 1'b0, lat, bc);
      checks++;
      if (lat !== 18 || bc !== 18 || bus.alu_out !== 18'd120000 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL mul_300x400: lat=%0d busy_cyc=%0d out=%0d busy=%b, exp 18/18/120000/0",
                  lat, bc, bus.alu_out, bus.busy);
      end
      // A start during the done cycle is accepted normally.
      single_op(OP_ADD, 18'd100, 18'd23);
      checks++;
      if (bus.done !== 1'b1 || bus.alu_out !== 18'd123) begin
         errors++;
         $display("FAIL start_on_done: done=%b out=%0d, exp 1/123", bus.done, bus.alu_out);
      end
      run_mul(18'd1000, 18'd1000, 1'b0, lat, bc);
      checks++;
      if (lat !== 18 || bus.alu_out !== 18'd213568 || bus.z_flag !== 1'b0) begin
         errors++;
         $display("FAIL mul_1000x1000: lat=%0d out=%0d z=%b, exp 18/213568/0",
                  lat, bus.alu_out, bus.z_flag);
      end
      run_mul(18'd0, 18'd77, 1'b0, lat, bc);
      checks++;
      if (lat !== 18 || bus.alu_out !== 18'd0 || bus.z_flag !== 1'b1) begin
         errors++;
         $display("FAIL mul_zero: lat=%0d out=%0d z=%b, exp 18/0/1", lat, bus.alu_out, bus.z_flag);
      end
      run_mul(18'd5, 18'd131072, 1'b0, lat, bc);   // 5 * 2^17 wraps to 2^17
      checks++;
      if (lat !== 18 || bus.alu_out !== 18'd131072) begin
         errors++;
         $display("FAIL mul_msb: lat=%0d out=%0d, exp 18/131072", lat, bus.alu_out);
      end
   endtask

   task automatic test_mul_ignore();
      int lat;
      int bc;
      int pulses;
      run_mul(18'd300, 18'd400, 1'b1, lat, bc);
      checks++;
      if (lat !== 18 || bus.alu_out !== 18'd120000) begin
         errors++;
         $display("FAIL mul_ignore: lat=%0d out=%0d, exp 18/120000", lat, bus.alu_out);
      end
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.done === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== 0 || bus.alu_out !== 18'd120000) begin
         errors++;
         $display("FAIL mul_single_done: extra_pulses=%0d out=%0d, exp 0/120000", pulses, bus.alu_out);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] exp_v;
      logic [2:0]   ops[5];
      logic [W-1:0] as[5];
      logic [W-1:0] bs[5];
      ops = '{OP_ADD, OP_SUB, OP_INC, OP_PASS_B, OP_CLR};
      as  = '{18'd10, 18'd50, 18'd99, 18'd1, 18'd7};
      bs  = '{18'd20, 18'd8,  18'd0,  18'd42, 18'd3};
      exp_q = '{18'd30, 18'd42, 18'd100, 18'd42, 18'd0};
      for (int i = 0; i < 5; i++) begin
         drive(ops[i], as[i], bs[i]);
         tick();
         exp_v = exp_q.pop_front();
         checks++;
         if (bus.done !== 1'b1 || bus.alu_out !== exp_v) begin
            errors++;
            $display("FAIL b2b[%0d]: done=%b out=%0d, exp 1/%0d", i, bus.done, bus.alu_out, exp_v);
         end
      end
      bus.start = 1'b0;
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.z_flag !== 1'b1) begin
         errors++;
         $display("FAIL b2b_end: done=%b z=%b, exp 0/1", bus.done, bus.z_flag);
      end
   endtask

   task automatic test_reset_mid_mul();
      int pulses;
      single_op(OP_ADD, 18'd2, 18'd3);
      drive(OP_MUL, 18'd300, 18'd400);
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      rstn = 1'b0;
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.alu_out !== 18'd0 || state_dbg !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_mul: busy=%b done=%b out=%0d st=%b, exp 0/0/0/0",
                  bus.busy, bus.done, bus.alu_out, state_dbg);
      end
      rstn = 1'b1;
      pulses = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         errors++;
         $display("FAIL no_done_after_reset: activity_cycles=%0d, exp 0", pulses);
      end
      single_op(OP_ADD, 18'd2, 18'd3);
      single_op(OP_CLR, 18'd2, 18'd3);
      checks++;
      if (bus.done !== 1'b1 || bus.alu_out !== 18'd0 || bus.z_flag !== 1'b1) begin
         errors++;
         $display("FAIL clr: done=%b out=%0d z=%b, exp 1/0/1", bus.done, bus.alu_out, bus.z_flag);
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      checks     = 0;
      errors     = 0;
      rstn       = 1'b0;
      bus.start  = 1'b0;
      bus.alu_op = 3'b000;
      bus.alu_a  = '0;
      bus.alu_b  = '0;
      test_reset();
      test_add();
      test_wrap();
      test_mul();
      test_mul_ignore();
      test_back_to_back();
      test_reset_mid_mul();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
